// File: rtl/gem_clct_match_sched_if.sv
// Handshake and bus bundle between the candidate source/encoder/match stage
// and the GEM-CLCT match scheduler.
interface gem_clct_match_sched_if #(
  parameter int unsigned MAX_CAND = 16,
  parameter int unsigned IDXW     = 4
);
  logic                    start;
  logic [10*MAX_CAND-1:0]  cand_pri;
  logic [MAX_CAND-1:0]     cand_vld;
  logic [79:0]             enc_pri;
  logic [9:0]              enc_pri_best;
  logic [2:0]              enc_win_best;
  logic                    busy;
  logic                    start_drop;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_found;
  logic [9:0]              out_pri;
  logic [IDXW-1:0]         out_idx;
  logic [IDXW:0]           out_ncand;

  modport master (
    output start, cand_pri, cand_vld, enc_pri_best, enc_win_best, out_ready,
    input  enc_pri, busy, start_drop, out_valid, out_found, out_pri, out_idx, out_ncand
  );

  modport slave (
    input  start, cand_pri, cand_vld, enc_pri_best, enc_win_best, out_ready,
    output enc_pri, busy, start_drop, out_valid, out_found, out_pri, out_idx, out_ncand
  );
endinterface

// File: rtl/gem_clct_match_sched.sv
// Drives the 8-input bending-angle minimum encoder over MAX_CAND candidates,
// one batch per clock, and keeps the global minimum across batches.
module gem_clct_match_sched #(
  parameter int unsigned MAX_CAND  = 16,
  parameter int unsigned IDXW      = 4,
  parameter logic [9:0]  ANGLE_MAX = 10'd511
) (
  input  logic                   clock,
  input  logic                   reset_n,
  gem_clct_match_sched_if.slave  bus
);

  localparam int unsigned NB = MAX_CAND / 8;
  localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned NW = IDXW + 1;
  localparam logic [9:0]  SENTINEL = 10'h3FF;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t          state_q;
  logic [79:0]     cand_q [NB];
  logic [BW-1:0]   batch_q;
  logic [9:0]      best_q;
  logic [IDXW-1:0] idx_q;
  logic [79:0]     enc_pri_q;
  logic            busy_q, start_drop_q, out_valid_q, out_found_q;
  logic [9:0]      out_pri_q;
  logic [IDXW-1:0] out_idx_q;
  logic [NW-1:0]   out_ncand_q;

  logic [79:0]     masked [NB];
  logic [NW-1:0]   ncand;
  logic [BW-1:0]   batch_nxt;
  logic [BW-1:0]   cmp_b;
  logic            cmp_en;
  logic [9:0]      best_d;
  logic [IDXW-1:0] idx_d;

  // Masked snapshot of the candidate inputs and surviving-entry count
  always_comb begin
    ncand = '0;
    for (int b = 0; b < NB; b++) begin
      masked[b] = '1;
      for (int j = 0; j < 8; j++) begin
        if (bus.cand_vld[8*b+j] && (bus.cand_pri[10*(8*b+j) +: 10] <= ANGLE_MAX)) begin
          masked[b][10*j +: 10] = bus.cand_pri[10*(8*b+j) +: 10];
          ncand = ncand + NW'(1);
        end
      end
    end
  end

  // Encoder result visible now belongs to the batch issued one clock earlier
  always_comb begin
    batch_nxt = batch_q + BW'(1);
    cmp_en    = ((state_q == ISSUE) && (batch_q != '0)) || (state_q == DRAIN);
    cmp_b     = (state_q == DRAIN) ? BW'(NB - 1) : (batch_q - BW'(1));
    best_d    = best_q;
    idx_d     = idx_q;
    if (cmp_en && (bus.enc_pri_best < best_q)) begin
      best_d = bus.enc_pri_best;
      idx_d  = IDXW'({cmp_b, bus.enc_win_best});
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      for (int b = 0; b < NB; b++) cand_q[b] <= '1;
      batch_q      <= '0;
      best_q       <= SENTINEL;
      idx_q        <= '0;
      enc_pri_q    <= '0;
      busy_q       <= 1'b0;
      start_drop_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_found_q  <= 1'b0;
      out_pri_q    <= SENTINEL;
      out_idx_q    <= '0;
      out_ncand_q  <= '0;
    end else begin
      start_drop_q <= bus.start && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            cand_q      <= masked;
            enc_pri_q   <= masked[0];
            batch_q     <= '0;
            best_q      <= SENTINEL;
            idx_q       <= '0;
            out_ncand_q <= ncand;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          best_q <= best_d;
          idx_q  <= idx_d;
          if (batch_q == BW'(NB - 1)) begin
            state_q <= DRAIN;
          end else begin
            batch_q   <= batch_nxt;
            enc_pri_q <= cand_q[batch_nxt];
          end
        end
        DRAIN: begin
          best_q      <= best_d;
          idx_q       <= idx_d;
          out_pri_q   <= best_d;
          out_idx_q   <= idx_d;
          out_found_q <= (best_d != SENTINEL);
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.enc_pri    = enc_pri_q;
  assign bus.busy       = busy_q;
  assign bus.start_drop = start_drop_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_found  = out_found_q;
  assign bus.out_pri    = out_pri_q;
  assign bus.out_idx    = out_idx_q;
  assign bus.out_ncand  = out_ncand_q;

endmodule

// File: tb/tb_gem_clct_match_sched.sv
// Directed and randomized checks of gem_clct_match_sched against a candidate-level
// reference model, with a behavioural registered 8-input minimum encoder.
module tb_gem_clct_match_sched;

  localparam int unsigned MAX_CAND = 16;
  localparam int unsigned IDXW     = 4;
  localparam int unsigned PW       = 10 * MAX_CAND;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  gem_clct_match_sched_if #(.MAX_CAND(MAX_CAND), .IDXW(IDXW)) bus ();

  gem_clct_match_sched #(.MAX_CAND(MAX_CAND), .IDXW(IDXW), .ANGLE_MAX(10'd511)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Registered encoder: minimum of 8 angles, lower input wins ties
  always @(posedge clock or negedge reset_n) begin : enc_model
    logic [9:0] m;
    logic [2:0] w;
    if (!reset_n) begin
      bus.enc_pri_best <= 10'h3FF;
      bus.enc_win_best <= 3'd0;
    end else begin
      m = bus.enc_pri[9:0];
      w = 3'd0;
      for (int j = 1; j < 8; j++) begin
        if (bus.enc_pri[10*j +: 10] < m) begin
          m = bus.enc_pri[10*j +: 10];
          w = 3'(j);
        end
      end
      bus.enc_pri_best <= m;
      bus.enc_win_best <= w;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] fill(input logic [9:0] v);
    logic [PW-1:0] p;
    for (int i = 0; i < MAX_CAND; i++) p[10*i +: 10] = v;
    return p;
  endfunction

  // First strictly smallest surviving angle in index order
  function automatic void model(input logic [PW-1:0] pri, input logic [MAX_CAND-1:0] vld,
                                output logic found, output logic [9:0] bp,
                                output logic [IDXW-1:0] bi, output logic [IDXW:0] n);
    bp = 10'h3FF; bi = '0; n = '0;
    for (int i = 0; i < MAX_CAND; i++) begin
      if (vld[i] && pri[10*i +: 10] <= 10'd511) begin
        n = n + 1'b1;
        if (pri[10*i +: 10] < bp) begin
          bp = pri[10*i +: 10];
          bi = IDXW'(i);
        end
      end
    end
    found = (n != 0);
  endfunction

  // One full event: start in cycle 0, result expected in cycle 4, held for 'hold' clocks
  task automatic run_event(input logic [PW-1:0] pri, input logic [MAX_CAND-1:0] vld,
                           input int hold, input string tag);
    logic            e_found;
    logic [9:0]      e_pri;
    logic [IDXW-1:0] e_idx;
    logic [IDXW:0]   e_n;
    int              k;
    model(pri, vld, e_found, e_pri, e_idx, e_n);
    @(negedge clock);
    bus.cand_pri = pri;
    bus.cand_vld = vld;
    bus.start    = 1'b1;
    @(negedge clock);
    bus.start    = 1'b0;
    bus.cand_pri = {5{$urandom()}};
    bus.cand_vld = 16'($urandom());
    chk({tag, ".busy_c1"}, 32'(bus.busy), 32'd1);
    k = 1;
    while (!bus.out_valid && k < 20) begin
      @(negedge clock);
      k++;
    end
    chk({tag, ".latency"}, 32'(k), 32'd4);
    chk({tag, ".found"}, 32'(bus.out_found), 32'(e_found));
    chk({tag, ".pri"},   32'(bus.out_pri),   32'(e_pri));
    chk({tag, ".idx"},   32'(bus.out_idx),   32'(e_idx));
    chk({tag, ".ncand"}, 32'(bus.out_ncand), 32'(e_n));
    for (int h = 0; h < hold; h++) begin
      bus.start = (h == 2);
      @(negedge clock);
      bus.start = 1'b0;
      chk({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, ".hold_pri"},   32'(bus.out_pri),   32'(e_pri));
      chk({tag, ".hold_idx"},   32'(bus.out_idx),   32'(e_idx));
      chk({tag, ".hold_busy"},  32'(bus.busy),      32'd1);
      if (h == 2) chk({tag, ".start_drop"}, 32'(bus.start_drop), 32'd1);
    end
    bus.out_ready = 1'b1;
    bus.start     = (hold > 0);
    @(negedge clock);
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    chk({tag, ".retire_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".retire_busy"},  32'(bus.busy),      32'd0);
    if (hold > 0) chk({tag, ".hs_drop"}, 32'(bus.start_drop), 32'd1);
  endtask

  initial begin
    logic [PW-1:0]       p;
    logic [MAX_CAND-1:0] v;

    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.cand_pri  = '0;
    bus.cand_vld  = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst.busy",       32'(bus.busy),       32'd0);
    chk("rst.out_valid",  32'(bus.out_valid),  32'd0);
    chk("rst.out_found",  32'(bus.out_found),  32'd0);
    chk("rst.out_pri",    32'(bus.out_pri),    32'h3FF);
    chk("rst.out_idx",    32'(bus.out_idx),    32'd0);
    chk("rst.out_ncand",  32'(bus.out_ncand),  32'd0);
    chk("rst.enc_pri",    32'(bus.enc_pri[31:0]), 32'd0);
    chk("rst.start_drop", 32'(bus.start_drop), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    p = fill(10'd200); p[10*11 +: 10] = 10'd37;
    run_event(p, 16'hFFFF, 0, "t1");

    p = fill(10'd99); p[10*3 +: 10] = 10'd5; p[10*9 +: 10] = 10'd5; p[10*14 +: 10] = 10'd5;
    run_event(p, 16'hFFFF, 0, "t2a");
    p = fill(10'd99); p[10*9 +: 10] = 10'd5; p[10*14 +: 10] = 10'd5;
    run_event(p, 16'hFFFF, 0, "t2b");

    p = '0; p[0 +: 10] = 10'd600; p[10 +: 10] = 10'd1; p[70 +: 10] = 10'd300;
    run_event(p, 16'h0081, 0, "t3");

    run_event(fill(10'd3), 16'h0000, 0, "t4");

    p = fill(10'd400); p[10*2 +: 10] = 10'd511; p[10*15 +: 10] = 10'd512;
    run_event(p, 16'hFFFF, 10, "t5");
    p = fill(10'd50); p[10*8 +: 10] = 10'd0;
    run_event(p, 16'hFFFF, 0, "t5_after");

    // Reset mid-event: no result may appear afterwards
    @(negedge clock);
    bus.cand_pri = fill(10'd7);
    bus.cand_vld = 16'hFFFF;
    bus.start    = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("t6.busy_rst",  32'(bus.busy),      32'd0);
    chk("t6.valid_rst", 32'(bus.out_valid), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk("t6.no_result", 32'(bus.out_valid), 32'd0);
      chk("t6.idle_busy", 32'(bus.busy),      32'd0);
    end
    p = fill(10'd300); p[10*6 +: 10] = 10'd12;
    run_event(p, 16'hFFBF, 0, "t6_fresh");

    for (int e = 0; e < 24; e++) begin
      for (int i = 0; i < MAX_CAND; i++) begin
        case (e % 3)
          0:       p[10*i +: 10] = 10'($urandom_range(0, 7));
          1:       p[10*i +: 10] = 10'($urandom_range(0, 1023));
          default: p[10*i +: 10] = 10'($urandom_range(400, 700));
        endcase
      end
      v = (e % 3 == 2) ? 16'($urandom() & $urandom()) : 16'($urandom());
      run_event(p, v, int'($urandom_range(0, 4)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
